conway_life_grid: RTL and testbench



---
 rtl/conway_life_grid.sv | 89 ++++++++
 tb/tb_conway_life_grid.sv | 139 +++++++++++++
 2 files changed

// File: rtl/conway_life_grid.sv
// conway_life_grid
//   Conway's Game of Life engine over a ROWS x COLS cell array. Each clock
//   edge either loads a new board from 'data' or advances the board by one
//   generation, with every cell updated in parallel from the registered
//   board 'q'.
//
//   Cell (r,c) is bit r*COLS+c: row 0 in the LSBs, column 0 the LSB of a row.
//
//   Build option:
//     LIFE_TORUS_EN  defined     -> neighbour rows/cols wrap (toroidal grid)
//                    not defined -> off-grid neighbours read as dead
//
// Parameters:
//   ROWS   number of rows    (>= 3)
//   COLS   number of columns (>= 3)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears the board
//   load   when high, the board is replaced by 'data' at the next edge
//   data   board to load (ROWS*COLS bits)
//   q      current board (registered), 1 = alive

module conway_life_grid #(
    parameter int ROWS = 16,
    parameter int COLS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] data,
    output logic [ROWS*COLS-1:0] q
);

    logic [ROWS*COLS-1:0] next_gen;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            // Wrapped neighbour coordinates. In the flat build they are only
            // used as in-range indices; the valid flags below zero them out.
            localparam int RU = (r + ROWS - 1) % ROWS;
            localparam int RD = (r + 1) % ROWS;
            localparam int CL = (c + COLS - 1) % COLS;
            localparam int CR = (c + 1) % COLS;
            localparam int ME = r * COLS + c;

            logic [7:0] nb;
            logic [3:0] cnt;

`ifdef LIFE_TORUS_EN
            assign nb = {q[RU*COLS+CL], q[RU*COLS+c], q[RU*COLS+CR],
                         q[r*COLS+CL],                q[r*COLS+CR],
                         q[RD*COLS+CL], q[RD*COLS+c], q[RD*COLS+CR]};
`else
            localparam bit HU = (r > 0);
            localparam bit HD = (r < ROWS - 1);
            localparam bit HL = (c > 0);
            localparam bit HR = (c < COLS - 1);

            // Constant-false terms fold away, so no wrap paths exist here.
            assign nb = {(HU && HL) ? q[RU*COLS+CL] : 1'b0,
                         HU         ? q[RU*COLS+c]  : 1'b0,
                         (HU && HR) ? q[RU*COLS+CR] : 1'b0,
                         HL         ? q[r*COLS+CL]  : 1'b0,
                         HR         ? q[r*COLS+CR]  : 1'b0,
                         (HD && HL) ? q[RD*COLS+CL] : 1'b0,
                         HD         ? q[RD*COLS+c]  : 1'b0,
                         (HD && HR) ? q[RD*COLS+CR] : 1'b0};
`endif

            assign cnt = 4'(nb[0]) + 4'(nb[1]) + 4'(nb[2]) + 4'(nb[3])
                       + 4'(nb[4]) + 4'(nb[5]) + 4'(nb[6]) + 4'(nb[7]);

            // Birth on 3, survival on 2 (keeps current state), death otherwise.
            assign next_gen[ME] = (cnt == 4'd3) | ((cnt == 4'd2) & q[ME]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= data;
        end else begin
            q <= next_gen;
        end
    end

endmodule

// File: tb/tb_conway_life_grid.sv
// tb_conway_life_grid
//   Directed bench for conway_life_grid on a 4x4 board. Expected boards are
//   hand-computed; the toroidal or flat sequence is selected by the same
//   LIFE_TORUS_EN macro as the design build.

module tb_conway_life_grid;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] data;
    logic [15:0] q;

    int vectors;
    int miscompares;

    conway_life_grid #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .data  (data),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef LIFE_TORUS_EN
    localparam logic [15:0] BLINK_1 = 16'h2022;
    localparam logic [15:0] BLINK_2 = 16'h0007;
    localparam logic [15:0] BLINK_3 = 16'h2022;
    localparam logic [15:0] BLINK_4 = 16'h0007;
`else
    localparam logic [15:0] BLINK_1 = 16'h0022;
    localparam logic [15:0] BLINK_2 = 16'h0000;
    localparam logic [15:0] BLINK_3 = 16'h0000;
    localparam logic [15:0] BLINK_4 = 16'h0000;
`endif

    // Advance one edge and settle just past it before checking or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] expected);
        vectors++;
        assert (q === expected) else begin
            miscompares++;
            $error("FAIL %s: q=%h expected %h", tag, q, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        load  = 1'b0;
        data  = 16'h0000;
        #12;
        check("reset_initial", 16'h0000);

        rst_n = 1'b1;
        tick();
        check("idle_zero_1", 16'h0000);
        tick();
        check("idle_zero_2", 16'h0000);

        // Single-edge load of a horizontal blinker in row 0.
        load = 1'b1;
        data = 16'h0007;
        tick();
        check("load_blinker", 16'h0007);
        load = 1'b0;
        data = 16'hffff;
        tick();
        check("blink_gen1", BLINK_1);
        tick();
        check("blink_gen2", BLINK_2);
        tick();
        check("blink_gen3", BLINK_3);
        tick();
        check("blink_gen4", BLINK_4);

        // Load a block so the board is nonzero, then reset between edges.
        load = 1'b1;
        data = 16'h0033;
        tick();
        check("load_block", 16'h0033);
        load = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 16'h0000);
        load = 1'b1;
        data = 16'hffff;
        tick();
        check("reset_held_over_load", 16'h0000);
        rst_n = 1'b1;
        load  = 1'b0;
        tick();
        check("post_reset_zero", 16'h0000);

        // Still life: a 2x2 block must be stable for 10 generations.
        load = 1'b1;
        data = 16'h0033;
        tick();
        check("load_still", 16'h0033);
        load = 1'b0;
        data = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("still_gen%0d", i + 1), 16'h0033);
        end

        // Load held high keeps reloading; evolution starts when it drops.
        load = 1'b1;
        data = 16'h0007;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("load_hold%0d", i + 1), 16'h0007);
        end
        load = 1'b0;
        tick();
        check("load_release", BLINK_1);

        // data changes while load is low must not disturb evolution.
        data = 16'hffff;
        tick();
        check("data_ignored", BLINK_2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
